scr_port_arbiter: RTL and testbench

Shares the single-port 256x10 scratch RAM between the CPU execute stage and an external DMA/debug requester. The CPU is the default owner. The DMA side wins the RAM through a request/grant handshake and performs fixed-length bursts with an auto-incrementing address. While the DMA owns the RAM, a CPU access stalls the pipeline. A starvation counter guarantees the DMA side forward progress.

---
 rtl/scr_port_arbiter_if.sv | 50 +++++
 rtl/scr_port_arbiter.sv | 98 +++++++++
 tb/tb_scr_port_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/scr_port_arbiter_if.sv
// scr_port_arbiter_if -- bundle of the scratch-RAM sharing signals.
//   CPU execute stage : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_rdata, cpu_stall
//   DMA/debug side    : dma_req, dma_we, dma_addr, dma_len, dma_wdata
//                       -> dma_gnt, dma_beat, dma_rdata, dma_done
//   Scratch RAM       : ram_we, ram_addr, ram_wdata -> ram_rdata (combinational read)
// Modports: slave = the arbiter, master = the requesters plus RAM around it.
interface scr_port_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 10
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [ADDR_W-1:0] dma_len;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_beat;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_done;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
      output dma_gnt, dma_beat, dma_rdata, dma_done,
      output ram_we, ram_addr, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
      input  dma_gnt, dma_beat, dma_rdata, dma_done,
      input  ram_we, ram_addr, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/scr_port_arbiter.sv
// scr_port_arbiter -- shares the single-port scratch RAM between the CPU
// execute stage (default owner) and a DMA/debug requester doing fixed-length,
// auto-incrementing bursts. A starvation counter forces a DMA grant after
// MAX_STARVE consecutive denied request cycles.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : scr_port_arbiter_if.slave (CPU, DMA and RAM signal groups)
module scr_port_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 10,
   parameter int MAX_STARVE = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   scr_port_arbiter_if.slave    bus
);

   typedef enum logic {S_CPU, S_DMA} state_t;

   localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

   state_t            state, state_next;
   logic [ADDR_W-1:0] addr_cnt;
   logic [ADDR_W-1:0] beats_left;
   logic              burst_we;
   logic [3:0]        starve_cnt;
   logic              gnt_q;
   logic              grant;

   always_ff @(posedge clk) begin
      if (rst) state <= S_CPU;
      else     state <= state_next;
   end

   always_comb begin
      state_next    = state;
      grant         = 1'b0;
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_wdata = bus.cpu_wdata;
      bus.ram_we    = bus.cpu_req & bus.cpu_we;
      bus.cpu_rdata = bus.ram_rdata;
      bus.cpu_stall = 1'b0;
      bus.dma_beat  = 1'b0;
      bus.dma_done  = 1'b0;
      bus.dma_rdata = {DATA_W{1'b0}};
      case (state)
         S_CPU: begin
            grant = bus.dma_req & (~bus.cpu_req | (starve_cnt == STARVE_MAX));
            if (grant) state_next = S_DMA;
         end
         S_DMA: begin
            bus.ram_addr  = addr_cnt;
            bus.ram_wdata = bus.dma_wdata;
            bus.ram_we    = burst_we;
            bus.cpu_rdata = {DATA_W{1'b0}};
            bus.dma_rdata = bus.ram_rdata;
            bus.cpu_stall = bus.cpu_req;
            bus.dma_beat  = 1'b1;
            bus.dma_done  = (beats_left == '0);
            // Leaving DMA always passes through one CPU cycle, since grant is
            // only evaluated in S_CPU; this is what rules out back-to-back bursts.
            if (beats_left == '0) state_next = S_CPU;
         end
         default: state_next = S_CPU;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         gnt_q      <= 1'b0;
         addr_cnt   <= '0;
         beats_left <= '0;
         burst_we   <= 1'b0;
      end else begin
         gnt_q <= grant;
         if (state == S_CPU) begin
            if (grant) begin
               addr_cnt   <= bus.dma_addr;
               beats_left <= bus.dma_len;
               burst_we   <= bus.dma_we;
               starve_cnt <= '0;
            end else if (bus.dma_req) begin
               if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
            end else begin
               starve_cnt <= '0;
            end
         end else begin
            addr_cnt   <= addr_cnt + 1'b1;
            beats_left <= beats_left - 1'b1;
         end
      end
   end

   assign bus.dma_gnt = gnt_q;

endmodule

// File: tb/tb_scr_port_arbiter.sv
module tb_scr_port_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic preload;
   int   checks = 0;
   int   errors = 0;
   logic [9:0] exp_d;
   logic [7:0] exp_a;
   int   found;

   always #5 clk = ~clk;

   scr_port_arbiter_if #(.ADDR_W(8), .DATA_W(10)) bus ();

   scr_port_arbiter #(.ADDR_W(8), .DATA_W(10), .MAX_STARVE(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Scratch RAM: each word preloaded to 0x200 | address.
   logic [9:0] mem [256];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= 10'h200 | 10'(i);
      end else if (bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_wdata;
      end
   end
   assign bus.ram_rdata = mem[bus.ram_addr];

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_len = '0; bus.dma_wdata = '0;
   endtask

   task automatic test_reset;
      rst = 1; preload = 1; idle_inputs();
      cyc(); preload = 0;
      cyc(); #1;
      checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", bus.cpu_stall); end
      checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b exp 0", bus.dma_gnt); end
      checks++; if (bus.dma_beat !== 1'b0) begin errors++; $display("FAIL rst_beat got %b exp 0", bus.dma_beat); end
      checks++; if (bus.dma_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.dma_done); end
      checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b exp 0", bus.ram_we); end
      checks++; if (bus.dma_rdata !== 10'h000) begin errors++; $display("FAIL rst_dma_rdata got %h exp 000", bus.dma_rdata); end
      checks++; if (bus.cpu_rdata !== 10'h200) begin errors++; $display("FAIL rst_cpu_rdata got %h exp 200", bus.cpu_rdata); end
      cyc(); rst = 0;
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 10'h2A5; #1;
      checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL cpu_wr_we got %b exp 1", bus.ram_we); end
      checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_wr_stall got %b exp 0", bus.cpu_stall); end
      checks++; if (bus.ram_addr !== 8'h10 || bus.ram_wdata !== 10'h2A5) begin errors++; $display("FAIL cpu_wr_bus got %h/%h exp 10/2a5", bus.ram_addr, bus.ram_wdata); end
      cyc(); bus.cpu_we = 0; #1;
      checks++; if (bus.cpu_rdata !== 10'h2A5) begin errors++; $display("FAIL cpu_rd got %h exp 2a5", bus.cpu_rdata); end
      checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL cpu_rd_we got %b exp 0", bus.ram_we); end
   endtask

   task automatic test_idle_grant;
      cyc();
      bus.cpu_req = 0; bus.cpu_we = 0;
      bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 8'h20; bus.dma_len = 8'd3; #1;
      checks++; if (bus.dma_gnt !== 1'b0 || bus.dma_beat !== 1'b0) begin errors++; $display("FAIL ig_req_cycle got gnt %b beat %b exp 0 0", bus.dma_gnt, bus.dma_beat); end
      for (int k = 0; k < 4; k++) begin
         cyc(); bus.dma_req = 0; bus.dma_wdata = 10'h100 + 10'(k); #1;
         exp_a = 8'h20 + 8'(k);
         checks++; if (bus.dma_beat !== 1'b1) begin errors++; $display("FAIL ig_beat%0d got %b exp 1", k, bus.dma_beat); end
         checks++; if (bus.dma_gnt !== (k == 0)) begin errors++; $display("FAIL ig_gnt%0d got %b exp %b", k, bus.dma_gnt, k == 0); end
         checks++; if (bus.dma_done !== (k == 3)) begin errors++; $display("FAIL ig_done%0d got %b exp %b", k, bus.dma_done, k == 3); end
         checks++; if (bus.ram_addr !== exp_a || bus.ram_we !== 1'b1 || bus.ram_wdata !== 10'h100 + 10'(k)) begin
            errors++; $display("FAIL ig_wr%0d got %h/%b/%h exp %h/1/%h", k, bus.ram_addr, bus.ram_we, bus.ram_wdata, exp_a, 10'h100 + 10'(k)); end
      end
      cyc(); bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h23; #1;
      checks++; if (bus.dma_beat !== 1'b0 || bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL ig_after got beat %b stall %b exp 0 0", bus.dma_beat, bus.cpu_stall); end
      checks++; if (bus.cpu_rdata !== 10'h103) begin errors++; $display("FAIL ig_readback got %h exp 103", bus.cpu_rdata); end
   endtask

   task automatic test_starvation;
      for (int c = 0; c < 5; c++) begin
         cyc();
         if (c == 0) begin
            bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'h40; bus.cpu_wdata = 10'h155;
            bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 8'h50; bus.dma_len = 8'd1;
         end
         #1;
         checks++; if (bus.dma_gnt !== 1'b0 || bus.dma_beat !== 1'b0 || bus.cpu_stall !== 1'b0) begin
            errors++; $display("FAIL starve_wait%0d got gnt %b beat %b stall %b exp 0 0 0", c, bus.dma_gnt, bus.dma_beat, bus.cpu_stall); end
      end
      for (int b = 0; b < 2; b++) begin
         cyc();
         if (b == 0) begin bus.dma_req = 0; bus.cpu_addr = 8'h41; bus.cpu_wdata = 10'h0AA; end
         #1;
         exp_d = 10'h250 + 10'(b);
         checks++; if (bus.dma_gnt !== (b == 0)) begin errors++; $display("FAIL starve_gnt%0d got %b exp %b", b, bus.dma_gnt, b == 0); end
         checks++; if (bus.cpu_stall !== 1'b1 || bus.dma_beat !== 1'b1) begin errors++; $display("FAIL starve_stall%0d got stall %b beat %b exp 1 1", b, bus.cpu_stall, bus.dma_beat); end
         checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL starve_no_cpu_wr%0d got %b exp 0", b, bus.ram_we); end
         checks++; if (bus.dma_rdata !== exp_d || bus.cpu_rdata !== 10'h000) begin errors++; $display("FAIL starve_rd%0d got %h/%h exp %h/000", b, bus.dma_rdata, bus.cpu_rdata, exp_d); end
         checks++; if (bus.dma_done !== (b == 1)) begin errors++; $display("FAIL starve_done%0d got %b exp %b", b, bus.dma_done, b == 1); end
      end
      cyc(); bus.cpu_we = 0; #1;
      checks++; if (bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 10'h241) begin errors++; $display("FAIL starve_after got stall %b rd %h exp 0 241", bus.cpu_stall, bus.cpu_rdata); end
      cyc(); bus.cpu_addr = 8'h40; #1;
      checks++; if (bus.cpu_rdata !== 10'h155) begin errors++; $display("FAIL starve_cpu_wr got %h exp 155", bus.cpu_rdata); end
   endtask

   task automatic test_wrap_single;
      cyc();
      bus.cpu_req = 0; bus.cpu_we = 0;
      bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 8'hFE; bus.dma_len = 8'd2; #1;
      for (int b = 0; b < 3; b++) begin
         cyc(); if (b == 0) bus.dma_req = 0; #1;
         exp_a = 8'hFE + 8'(b);
         exp_d = 10'h200 | {2'b00, exp_a};
         checks++; if (bus.ram_addr !== exp_a || bus.dma_rdata !== exp_d) begin errors++; $display("FAIL wrap%0d got %h/%h exp %h/%h", b, bus.ram_addr, bus.dma_rdata, exp_a, exp_d); end
         checks++; if (bus.dma_done !== (b == 2)) begin errors++; $display("FAIL wrap_done%0d got %b exp %b", b, bus.dma_done, b == 2); end
      end
      cyc(); bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 8'h33; bus.dma_len = 8'd0; #1;
      checks++; if (bus.dma_beat !== 1'b0) begin errors++; $display("FAIL wrap_after got %b exp 0", bus.dma_beat); end
      cyc(); bus.dma_req = 0; #1;
      checks++; if (bus.dma_gnt !== 1'b1 || bus.dma_done !== 1'b1 || bus.dma_beat !== 1'b1) begin
         errors++; $display("FAIL single got gnt %b done %b beat %b exp 1 1 1", bus.dma_gnt, bus.dma_done, bus.dma_beat); end
      checks++; if (bus.dma_rdata !== 10'h233) begin errors++; $display("FAIL single_rd got %h exp 233", bus.dma_rdata); end
      cyc(); #1;
      checks++; if (bus.dma_beat !== 1'b0 || bus.dma_done !== 1'b0) begin errors++; $display("FAIL single_after got beat %b done %b exp 0 0", bus.dma_beat, bus.dma_done); end
   endtask

   task automatic test_back_to_back;
      cyc(); bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 8'h60; bus.dma_len = 8'd1; #1;
      for (int b = 0; b < 2; b++) begin
         cyc(); #1;
         checks++; if (bus.dma_beat !== 1'b1 || bus.dma_done !== (b == 1)) begin errors++; $display("FAIL b2b_first%0d got beat %b done %b exp 1 %b", b, bus.dma_beat, bus.dma_done, b == 1); end
      end
      cyc(); #1;
      checks++; if (bus.dma_beat !== 1'b0 || bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL b2b_gap got beat %b gnt %b exp 0 0", bus.dma_beat, bus.dma_gnt); end
      cyc(); bus.dma_req = 0; #1;
      checks++; if (bus.dma_gnt !== 1'b1 || bus.dma_beat !== 1'b1 || bus.ram_addr !== 8'h60) begin
         errors++; $display("FAIL b2b_second got gnt %b beat %b addr %h exp 1 1 60", bus.dma_gnt, bus.dma_beat, bus.ram_addr); end
      cyc(); #1;
      checks++; if (bus.dma_done !== 1'b1 || bus.ram_addr !== 8'h61) begin errors++; $display("FAIL b2b_done got %b addr %h exp 1 61", bus.dma_done, bus.ram_addr); end
      cyc(); #1;
      checks++; if (bus.dma_beat !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", bus.dma_beat); end
   endtask

   task automatic test_reset_mid;
      cyc(); bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 8'h70; bus.dma_len = 8'd7; #1;
      cyc(); bus.dma_req = 0; #1;
      checks++; if (bus.dma_gnt !== 1'b1 || bus.dma_beat !== 1'b1) begin errors++; $display("FAIL rm_beat1 got gnt %b beat %b exp 1 1", bus.dma_gnt, bus.dma_beat); end
      cyc(); rst = 1; #1;
      checks++; if (bus.dma_beat !== 1'b1 || bus.ram_addr !== 8'h71 || bus.dma_done !== 1'b0) begin
         errors++; $display("FAIL rm_beat2 got beat %b addr %h done %b exp 1 71 0", bus.dma_beat, bus.ram_addr, bus.dma_done); end
      cyc(); rst = 0; bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h10; #1;
      checks++; if (bus.dma_beat !== 1'b0 || bus.dma_done !== 1'b0 || bus.dma_gnt !== 1'b0 || bus.cpu_stall !== 1'b0) begin
         errors++; $display("FAIL rm_after got beat %b done %b gnt %b stall %b exp 0 0 0 0", bus.dma_beat, bus.dma_done, bus.dma_gnt, bus.cpu_stall); end
      checks++; if (bus.cpu_rdata !== 10'h2A5) begin errors++; $display("FAIL rm_cpu_rd got %h exp 2a5", bus.cpu_rdata); end
      for (int n = 0; n < 6; n++) begin
         cyc(); #1;
         checks++; if (bus.dma_done !== 1'b0 || bus.dma_beat !== 1'b0) begin errors++; $display("FAIL rm_quiet%0d got done %b beat %b exp 0 0", n, bus.dma_done, bus.dma_beat); end
      end
      // Build up three denied cycles, then reset: the forced grant must again take five cycles.
      cyc(); bus.dma_req = 1; bus.dma_addr = 8'h80; bus.dma_len = 8'd0;
      cyc(); cyc();
      cyc(); rst = 1;
      cyc(); rst = 0; #1;
      found = -1;
      for (int n = 0; n < 10; n++) begin
         if (n > 0) begin cyc(); #1; end
         if (found < 0 && bus.dma_gnt === 1'b1) found = n;
      end
      checks++; if (found != 5) begin errors++; $display("FAIL rm_starve_clear got grant cycle %0d exp 5", found); end
      bus.dma_req = 0; bus.cpu_req = 0;
      cyc(); cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got no end exp finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_idle_grant();
      test_starvation();
      test_wrap_single();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
